// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t    : one fetch queue slot {pc, data, filled, stale}
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_STEP          : byte increment between sequential fetches
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        filled;
        logic        stale;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue
// Circular buffer pairing each issued fetch address with its returned word.
// Entries are allocated when a request is accepted, filled in order as
// responses arrive, and popped from the head. Stale heads drain silently.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_alloc, i_alloc_pc   allocate next slot for an accepted request
//   i_fill, i_fill_data   memory response for the oldest unfilled slot
//   i_mark_stale          mark every slot stale (redirect)
//   i_pop_ready           consumer accepts the presented head
//   o_full                occupancy == DEPTH (registered)
//   o_head_valid          head is filled and not stale
//   o_head_data/o_head_pc head contents
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alloc,
    input  logic [31:0] i_alloc_pc,
    input  logic        i_fill,
    input  logic [31:0] i_fill_data,
    input  logic        i_mark_stale,
    input  logic        i_pop_ready,
    output logic        o_full,
    output logic        o_head_valid,
    output logic [31:0] o_head_data,
    output logic [31:0] o_head_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   r_q [DEPTH];
    logic [PW-1:0]  r_alloc_ptr;
    logic [PW-1:0]  r_fill_ptr;
    logic [PW-1:0]  r_head_ptr;
    logic [CW-1:0]  r_occ;
    logic [CW-1:0]  r_pending;

    fetch_entry_t   w_head;
    logic           w_head_live;
    logic           w_alloc;
    logic           w_fill;
    logic           w_pop;

    assign w_head      = r_q[r_head_ptr];
    assign w_head_live = (r_occ != '0) && w_head.filled;
    // Stale heads leave without waiting for the consumer.
    assign w_pop       = w_head_live && (w_head.stale || i_pop_ready);
    assign w_alloc     = i_alloc && (r_occ != CW'(DEPTH));
    // A response with nothing outstanding is dropped.
    assign w_fill      = i_fill && (r_pending != '0);

    assign o_full       = (r_occ == CW'(DEPTH));
    assign o_head_valid = w_head_live && !w_head.stale;
    assign o_head_data  = w_head.data;
    assign o_head_pc    = w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_occ       <= '0;
            r_pending   <= '0;
        end else begin
            // Free slots may pick up the flag too; alloc rewrites it below.
            if (i_mark_stale) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_q[i].stale <= 1'b1;
                end
            end
            // The alloc slot is always free, so it never collides with fill or head.
            if (w_alloc) begin
                r_q[r_alloc_ptr] <= '{pc: i_alloc_pc, data: 32'h0, filled: 1'b0, stale: i_mark_stale};
                r_alloc_ptr      <= r_alloc_ptr + PW'(1);
            end
            if (w_fill) begin
                r_q[r_fill_ptr].data   <= i_fill_data;
                r_q[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr             <= r_fill_ptr + PW'(1);
            end
            if (w_pop) begin
                r_head_ptr <= r_head_ptr + PW'(1);
            end
            r_occ     <= r_occ + CW'(w_alloc) - CW'(w_pop);
            r_pending <= r_pending + CW'(w_alloc) - CW'(w_fill);
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_fill && (r_pending == '0)));

endmodule

// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
// inst_fetch
// Instruction fetch stage: owns the fetch PC, issues word requests to
// instruction memory and hands {pc, word} pairs to decode via valid/ready.
// A redirect retargets the PC and marks every queued/in-flight fetch stale.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_rsp_valid/data              in-order response, no backpressure
//   redirect_valid/pc                control-flow change from execute
//   inst_valid/ready, inst_out/pc    instruction channel to decode
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    logic [31:0] r_fetch_pc;
    logic        r_started;

    logic        w_full;
    logic        w_accept;
    logic [31:0] w_redirect_pc;
    logic        w_unused_lsbs;

    // Low address bits of a redirect target are ignored.
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused_lsbs = ^redirect_pc[1:0];

    // Held low until the first edge after reset; then purely from the
    // registered occupancy, so inst_ready has no path to the request.
    assign imem_req_valid = r_started && !w_full;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_started  <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc      (w_accept),
        .i_alloc_pc   (r_fetch_pc),
        .i_fill       (imem_rsp_valid),
        .i_fill_data  (imem_rsp_data),
        .i_mark_stale (redirect_valid),
        .i_pop_ready  (inst_ready),
        .o_full       (w_full),
        .o_head_valid (inst_valid),
        .o_head_data  (inst_out),
        .o_head_pc    (inst_pc)
    );

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc;
    int          first_valid_cyc;
    int          n_xfer;
    int          n_acc;
    logic        watch;
    logic [31:0] first_pc;
    logic        acc_last;
    logic [31:0] last_acc_addr;
    logic        wrap_seen;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + 32'h0000_1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Called at a falling edge; applies inputs for the coming rising edge,
    // plays the 1-cycle memory, runs the scoreboard, then advances one cycle.
    task automatic step(input logic mem_rdy, input logic dec_rdy, input logic redir, input logic [31:0] rpc);
        exp_t e;
        imem_req_ready = mem_rdy;
        inst_ready     = dec_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        chk("req_addr", imem_req_addr, model_pc);
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid && dec_rdy) begin
            n_xfer++;
            if (watch) begin
                first_pc = inst_pc;
                watch    = 1'b0;
            end
            n_checks++;
            assert (exp_q.size() > 0) n_pass++;
            else $error("FAIL sb_has_entry: observed pc %h expected no instruction", inst_pc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_out", inst_out, e.data);
            end
        end
        acc_last = imem_req_valid && mem_rdy;
        if (acc_last) begin
            mem_q.push_back(imem_req_addr);
            exp_q.push_back('{pc: model_pc, data: mem_data(model_pc)});
            model_pc      = model_pc + 32'd4;
            last_acc_addr = imem_req_addr;
            n_acc++;
        end
        if (redir) begin
            exp_q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n           = 1'b1;
        cyc             = 0;
        first_valid_cyc = -1;
        n_xfer          = 0;
        n_acc           = 0;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        model_pc       = RST_PC;
        watch          = 1'b0;
        first_pc       = 32'hx;
        acc_last       = 1'b0;
        last_acc_addr  = 32'h0;
        wrap_seen      = 1'b0;
        cyc            = 0;
        first_valid_cyc = -1;
        n_xfer         = 0;
        n_acc          = 0;

        // Reset values
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        release_reset();

        // Streaming from reset: first instruction at cycle 3, then 1/cycle
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("req_valid_c1", 32'(imem_req_valid), 32'd1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
        n_xfer = 0;
        repeat (16) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("throughput", 32'(n_xfer), 32'd16);
        chk("first_valid_cyc", 32'(first_valid_cyc), 32'd3);

        // Asynchronous reset mid-cycle
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_req_addr", imem_req_addr, RST_PC);
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst_out", inst_out, 32'h0);
        chk("mid_rst_inst_pc", inst_pc, 32'h0);
        mem_q.delete();
        exp_q.delete();
        model_pc = RST_PC;
        @(negedge clk);
        release_reset();

        // Decode stalled: exactly DEPTH requests, head holds the reset-PC word
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_accepts", 32'(n_acc), 32'(DEPTH));
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_inst_pc", inst_pc, RST_PC);
        chk("stall_inst_out", inst_out, mem_data(RST_PC));
        n_xfer = 0;
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_release_xfers", 32'(n_xfer), 32'd12);

        // Redirect with several fetches buffered/in flight
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        chk("redir_addr_100", imem_req_addr, 32'h0000_0100);
        first_pc = 32'hx;
        watch    = 1'b1;
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_first_100", first_pc, 32'h0000_0100);

        // Redirect coinciding with acceptance and response; unaligned target
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        chk("redir_addr_200", imem_req_addr, 32'h0000_0200);
        first_pc = 32'hx;
        watch    = 1'b1;
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_first_200", first_pc, 32'h0000_0200);

        // Back-to-back redirects: last wins
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        chk("b2b_addr", imem_req_addr, 32'h0000_0400);
        first_pc = 32'hx;
        watch    = 1'b1;
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b_first", first_pc, 32'h0000_0400);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        first_pc  = 32'hx;
        watch     = 1'b1;
        wrap_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (!wrap_seen && acc_last && last_acc_addr == 32'hFFFF_FFFC) begin
                chk("wrap_addr", imem_req_addr, 32'h0000_0000);
                wrap_seen = 1'b1;
            end
        end
        chk("wrap_seen", 32'(wrap_seen), 32'd1);
        chk("wrap_first", first_pc, 32'hFFFF_FFF8);

        // Random memory/decode backpressure with occasional redirects
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), $urandom);
        end

        // Drain: stop issuing, everything owed must be delivered
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() > 0 || mem_q.size() > 0) step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_inst_valid", 32'(inst_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
